// File: rtl/lfsr_bist_engine.sv
// lfsr_bist_engine
//   LFSR-based BIST engine. In PRPG mode it steps a Galois LFSR to feed
//   pseudo-random patterns to the circuit under test. In MISR mode it also
//   folds each response word into the register to build a signature. A run
//   takes a programmable number of steps. The final register value is then
//   captured as the signature and compared against a golden value.
//
// Ports
//   clk_i            clock, all state on the rising edge
//   reset_i          synchronous active-high reset
//   start_i          begin a run (honoured in IDLE/DONE only)
//   mode_i           0 = PRPG, 1 = MISR (sampled with start_i)
//   seed_load_i      load seed_i into the register (honoured in IDLE/DONE only)
//   seed_i           seed value; zero is replaced by 1
//   pattern_count_i  number of steps N (sampled with start_i)
//   misr_in_i        response word, XORed in on every MISR RUN cycle
//   expected_sig_i   golden signature, compared when DONE is entered
//   pattern_out_o    current register value
//   step_o / busy_o  high during RUN
//   done_o           one-cycle pulse in DONE
//   signature_o      register value captured on entry to DONE
//   pass_o           signature_o == expected_sig_i, captured with signature_o
module lfsr_bist_engine #(
  parameter int               WIDTH     = 5,
  parameter logic [WIDTH-1:0] POLY      = 5'b00101,
  parameter int               CNT_W     = 8,
  parameter logic [WIDTH-1:0] SEED_INIT = 5'b00001
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic [CNT_W-1:0] pattern_count_i,
  input  logic [WIDTH-1:0] misr_in_i,
  input  logic [WIDTH-1:0] expected_sig_i,
  output logic [WIDTH-1:0] pattern_out_o,
  output logic             step_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] signature_o,
  output logic             pass_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             busy_q, done_q, pass_q;
  logic [WIDTH-1:0] sig_q;

  logic [WIDTH-1:0] seed_val;
  logic [WIDTH-1:0] nxt_val;

  always_comb begin
    // An all-zero register would lock the LFSR, so a zero seed loads 1.
    seed_val = (seed_i == '0) ? WIDTH'(1) : seed_i;
    nxt_val  = {reg_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{reg_q[WIDTH-1]}} & POLY);
    if (mode_q) nxt_val = nxt_val ^ misr_in_i;
  end

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      RUN: begin
        reg_d = nxt_val;
        cnt_d = cnt_q - CNT_W'(1);
        // The counter is loaded with N > 0 and leaves RUN at 1, so it never wraps.
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      default: begin  // IDLE and DONE behave the same
        if (seed_load_i) reg_d = seed_val;
        if (start_i) begin
          mode_d  = mode_i;
          cnt_d   = pattern_count_i;
          state_d = (pattern_count_i == '0) ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State plus registered outputs. Outputs are decoded from the next state,
  // so they line up with the state they describe.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      reg_q   <= SEED_INIT;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sig_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
      if (state_d == DONE) begin
        sig_q  <= reg_d;
        pass_q <= (reg_d == expected_sig_i);
      end
    end
  end

  assign pattern_out_o = reg_q;
  assign step_o        = busy_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign signature_o   = sig_q;
  assign pass_o        = pass_q;

endmodule

// File: tb/tb_lfsr_bist_engine.sv
// Directed bench for lfsr_bist_engine with default parameters
// (WIDTH=5, POLY=00101, CNT_W=8, SEED_INIT=00001).
module tb_lfsr_bist_engine;

  logic       clk = 1'b0;
  logic       reset, start, mode, seed_load;
  logic [4:0] seed, misr_in, expected_sig;
  logic [7:0] pattern_count;
  logic [4:0] pattern_out, signature;
  logic       step, busy, done, pass;

  int n_cmp = 0;
  int n_err = 0;

  // Hand-derived sequence from 00001 for x^5+x^2+1 (Galois, mask 00101).
  localparam logic [4:0] SEQ [31] = '{
    5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00101, 5'b01010, 5'b10100,
    5'b01101, 5'b11010, 5'b10001, 5'b00111, 5'b01110, 5'b11100, 5'b11101, 5'b11111,
    5'b11011, 5'b10011, 5'b00011, 5'b00110, 5'b01100, 5'b11000, 5'b10101, 5'b01111,
    5'b11110, 5'b11001, 5'b10111, 5'b01011, 5'b10110, 5'b01001, 5'b10010};

  lfsr_bist_engine dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .mode_i(mode),
    .seed_load_i(seed_load), .seed_i(seed), .pattern_count_i(pattern_count),
    .misr_in_i(misr_in), .expected_sig_i(expected_sig),
    .pattern_out_o(pattern_out), .step_o(step), .busy_o(busy), .done_o(done),
    .signature_o(signature), .pass_o(pass));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int steps;
    reset = 1'b1; start = 1'b0; mode = 1'b0; seed_load = 1'b0; seed = '0;
    misr_in = '0; expected_sig = 5'b00001; pattern_count = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_pat", pattern_out, 5'b00001);
    chk("rst_busy", busy, 0);
    chk("rst_step", step, 0);
    chk("rst_done", done, 0);
    chk("rst_sig", signature, 0);
    chk("rst_pass", pass, 0);

    // 1: full PRPG period
    start = 1'b1; pattern_count = 8'd31; tick(); start = 1'b0;
    for (int k = 0; k < 31; k++) begin
      chk("t1_step", step, 1);
      chk("t1_pat", pattern_out, SEQ[k]);
      chk("t1_nodone", done, 0);
      tick();
    end
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_sig", signature, 5'b00001);
    chk("t1_pass", pass, 1);
    tick();
    chk("t1_pulse", done, 0);
    chk("t1_hold_sig", signature, 5'b00001);

    // 2: zero seed becomes 1; N=0 goes straight to DONE
    seed_load = 1'b1; seed = 5'b00000; tick(); seed_load = 1'b0;
    chk("t2_zseed", pattern_out, 5'b00001);
    start = 1'b1; pattern_count = 8'd0; tick(); start = 1'b0;
    chk("t2_done", done, 1);
    chk("t2_step", step, 0);
    chk("t2_busy", busy, 0);
    chk("t2_sig", signature, 5'b00001);
    tick();

    // 3: seed_load together with start
    seed_load = 1'b1; seed = 5'b10000; start = 1'b1; pattern_count = 8'd2;
    expected_sig = 5'b01010;
    tick(); seed_load = 1'b0; start = 1'b0;
    chk("t3_pat0", pattern_out, 5'b10000);
    chk("t3_step0", step, 1);
    tick();
    chk("t3_pat1", pattern_out, 5'b00101);
    tick();
    chk("t3_done", done, 1);
    chk("t3_sig", signature, 5'b01010);
    chk("t3_pass", pass, 1);
    tick();

    // 4: MISR from 00001: 00001 -(+00001)-> 00011 -(+00000)-> 00110
    seed_load = 1'b1; seed = 5'b00000; tick(); seed_load = 1'b0;
    mode = 1'b1; start = 1'b1; pattern_count = 8'd2; misr_in = 5'b00001;
    expected_sig = 5'b00110;
    tick(); start = 1'b0; mode = 1'b0;
    chk("t4_pat0", pattern_out, 5'b00001);
    tick(); misr_in = 5'b00000;
    chk("t4_pat1", pattern_out, 5'b00011);
    tick();
    chk("t4_done", done, 1);
    chk("t4_sig", signature, 5'b00110);
    chk("t4_pass", pass, 1);
    tick();
    seed_load = 1'b1; seed = 5'b00000; tick(); seed_load = 1'b0;
    mode = 1'b1; start = 1'b1; misr_in = 5'b00001; expected_sig = 5'b00011;
    tick(); start = 1'b0; mode = 1'b0;
    tick(); misr_in = 5'b00000;
    tick();
    chk("t4b_done", done, 1);
    chk("t4b_sig", signature, 5'b00110);
    chk("t4b_pass", pass, 0);
    tick();

    // 5: controls ignored during RUN; reset mid-run
    seed_load = 1'b1; seed = 5'b00001; start = 1'b1; pattern_count = 8'd20;
    tick(); seed_load = 1'b0; start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("t5_pat", pattern_out, SEQ[k]);
      chk("t5_busy", busy, 1);
      if (k == 5) begin
        seed_load = 1'b1; seed = 5'b11111; start = 1'b1; mode = 1'b1;
        pattern_count = 8'd3; misr_in = 5'b11111;
      end
      tick();
      seed_load = 1'b0; start = 1'b0; mode = 1'b0; misr_in = '0;
    end
    chk("t5_pat10", pattern_out, SEQ[10]);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_busy_rst", busy, 0);
    chk("t5_step_rst", step, 0);
    chk("t5_pat_rst", pattern_out, 5'b00001);
    chk("t5_sig_rst", signature, 0);
    chk("t5_pass_rst", pass, 0);
    for (int k = 0; k < 12; k++) begin
      chk("t5_nodone", done, 0);
      tick();
    end

    // 6: N=255, S(255) = S(7)
    expected_sig = 5'b10100;
    start = 1'b1; pattern_count = 8'd255; tick(); start = 1'b0;
    steps = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (step) begin
        if (pattern_out !== SEQ[steps % 31]) chk("t6_pat", pattern_out, SEQ[steps % 31]);
        steps++;
      end
      tick();
    end
    chk("t6_done", done, 1);
    chk("t6_steps", steps, 255);
    chk("t6_sig", signature, 5'b10100);
    chk("t6_pass", pass, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
